rggen_axi4lite_pipelined_adapter: RTL and testbench

AXI4-Lite slave front end for rggen register blocks. It supports multiple outstanding transactions, independent AW/W acceptance, and a selectable read/write arbitration mode. It drives the common register-bus request interface (valid/access/address/write data/strobe, then ready/status/read data) into the adapter-common block. B and R responses are buffered in per-channel queues so the master can leave bready/rready low without stalling the register bus until a queue fills.

---
 rtl/rggen_axi4lite_pipelined_adapter_pkg.sv | 14 +
 rtl/rggen_axi4lite_response_fifo.sv | 54 +++++
 rtl/rggen_axi4lite_pipelined_adapter.sv | 196 +++++++++++++++++++
 tb/tb_rggen_axi4lite_pipelined_adapter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_axi4lite_pipelined_adapter_pkg.sv
// Shared constants for the pipelined AXI4-Lite register-bus adapter.
package rggen_axi4lite_pipelined_adapter_pkg;
    localparam logic [1:0] RGGEN_WRITE = 2'b11;
    localparam logic [1:0] RGGEN_READ  = 2'b10;

    localparam int WRITE_FIRST = 0;
    localparam int READ_FIRST  = 1;
    localparam int ROUND_ROBIN = 2;

    // A zero-width ID still needs a 1-bit port.
    function automatic int clip_id_width(int width);
        return (width < 1) ? 1 : width;
    endfunction
endpackage

// File: rtl/rggen_axi4lite_response_fifo.sv
// Show-ahead response queue; head data reads as zero while empty.
module rggen_axi4lite_response_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign pop_ok  = i_pop && !o_empty;
    // A pop frees the slot the simultaneous push lands in.
    assign push_ok = i_push && (!o_full || pop_ok);
    assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
            else if (!push_ok && pop_ok) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_data;
    end
endmodule

// File: rtl/rggen_axi4lite_pipelined_adapter.sv
// AXI4-Lite slave front end for rggen register blocks with buffered B/R
// responses and a configurable read/write arbiter.
module rggen_axi4lite_pipelined_adapter
    import rggen_axi4lite_pipelined_adapter_pkg::*;
#(
    parameter int ID_WIDTH        = 0,
    parameter int ADDRESS_WIDTH   = 8,
    parameter int BUS_WIDTH       = 32,
    parameter int RESPONSE_DEPTH  = 2,
    parameter int ARBITRATION     = 0,
    parameter int ACTUAL_ID_WIDTH = clip_id_width(ID_WIDTH)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_awvalid,
    output logic                       o_awready,
    input  logic [ACTUAL_ID_WIDTH-1:0] i_awid,
    input  logic [ADDRESS_WIDTH-1:0]   i_awaddr,
    input  logic [2:0]                 i_awprot,
    input  logic                       i_wvalid,
    output logic                       o_wready,
    input  logic [BUS_WIDTH-1:0]       i_wdata,
    input  logic [BUS_WIDTH/8-1:0]     i_wstrb,
    output logic                       o_bvalid,
    input  logic                       i_bready,
    output logic [ACTUAL_ID_WIDTH-1:0] o_bid,
    output logic [1:0]                 o_bresp,
    input  logic                       i_arvalid,
    output logic                       o_arready,
    input  logic [ACTUAL_ID_WIDTH-1:0] i_arid,
    input  logic [ADDRESS_WIDTH-1:0]   i_araddr,
    input  logic [2:0]                 i_arprot,
    output logic                       o_rvalid,
    input  logic                       i_rready,
    output logic [ACTUAL_ID_WIDTH-1:0] o_rid,
    output logic [1:0]                 o_rresp,
    output logic [BUS_WIDTH-1:0]       o_rdata,
    output logic                       o_bus_valid,
    output logic [1:0]                 o_bus_access,
    output logic [ADDRESS_WIDTH-1:0]   o_bus_address,
    output logic [BUS_WIDTH-1:0]       o_bus_write_data,
    output logic [BUS_WIDTH/8-1:0]     o_bus_strobe,
    input  logic                       i_bus_ready,
    input  logic [1:0]                 i_bus_status,
    input  logic [BUS_WIDTH-1:0]       i_bus_read_data
);
    localparam int STRB_W = BUS_WIDTH / 8;
    localparam int B_W    = ACTUAL_ID_WIDTH + 2;
    localparam int R_W    = ACTUAL_ID_WIDTH + 2 + BUS_WIDTH;
    localparam int CNT_W  = $clog2(RESPONSE_DEPTH + 1);

    logic                       aw_held_q;
    logic [ACTUAL_ID_WIDTH-1:0] aw_id_q;
    logic [ADDRESS_WIDTH-1:0]   aw_addr_q;
    logic                       w_held_q;
    logic [BUS_WIDTH-1:0]       w_data_q;
    logic [STRB_W-1:0]          w_strb_q;
    logic                       ar_held_q;
    logic [ACTUAL_ID_WIDTH-1:0] ar_id_q;
    logic [ADDRESS_WIDTH-1:0]   ar_addr_q;
    logic                       lock_q;
    logic                       lock_write_q;
    logic                       rr_write_next_q;

    logic             write_req;
    logic             read_req;
    logic             grant_write;
    logic             bus_valid;
    logic             write_done;
    logic             read_done;
    logic [CNT_W-1:0] b_count;
    logic [CNT_W-1:0] r_count;
    logic             b_empty;
    logic             r_empty;
    logic             b_full_unused;
    logic             r_full_unused;
    logic             unused_inputs;
    logic [B_W-1:0]   b_head;
    logic [R_W-1:0]   r_head;

    assign write_req = aw_held_q && w_held_q && (b_count < CNT_W'(RESPONSE_DEPTH));
    assign read_req  = ar_held_q && (r_count < CNT_W'(RESPONSE_DEPTH));

    // A locked grant ignores fresh requests until the bus completes it.
    always_comb begin
        bus_valid   = 1'b0;
        grant_write = 1'b0;
        if (lock_q) begin
            bus_valid   = 1'b1;
            grant_write = lock_write_q;
        end else begin
            bus_valid = write_req || read_req;
            case (ARBITRATION)
                READ_FIRST:  grant_write = write_req && !read_req;
                ROUND_ROBIN: grant_write = write_req && (!read_req || rr_write_next_q);
                default:     grant_write = write_req;
            endcase
        end
    end

    assign write_done = bus_valid && i_bus_ready && grant_write;
    assign read_done  = bus_valid && i_bus_ready && !grant_write;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            aw_held_q       <= 1'b0;
            aw_id_q         <= '0;
            aw_addr_q       <= '0;
            w_held_q        <= 1'b0;
            w_data_q        <= '0;
            w_strb_q        <= '0;
            ar_held_q       <= 1'b0;
            ar_id_q         <= '0;
            ar_addr_q       <= '0;
            lock_q          <= 1'b0;
            lock_write_q    <= 1'b0;
            rr_write_next_q <= 1'b1;
        end else begin
            if (write_done) begin
                aw_held_q <= 1'b0;
            end else if (i_awvalid && !aw_held_q) begin
                aw_held_q <= 1'b1;
                aw_id_q   <= i_awid;
                aw_addr_q <= i_awaddr;
            end
            if (write_done) begin
                w_held_q <= 1'b0;
            end else if (i_wvalid && !w_held_q) begin
                w_held_q <= 1'b1;
                w_data_q <= i_wdata;
                w_strb_q <= i_wstrb;
            end
            if (read_done) begin
                ar_held_q <= 1'b0;
            end else if (i_arvalid && !ar_held_q) begin
                ar_held_q <= 1'b1;
                ar_id_q   <= i_arid;
                ar_addr_q <= i_araddr;
            end
            if (write_done || read_done) begin
                lock_q          <= 1'b0;
                rr_write_next_q <= !grant_write;
            end else if (bus_valid) begin
                lock_q       <= 1'b1;
                lock_write_q <= grant_write;
            end
        end
    end

    assign o_awready        = !aw_held_q;
    assign o_wready         = !w_held_q;
    assign o_arready        = !ar_held_q;
    assign o_bus_valid      = bus_valid;
    assign o_bus_access     = !bus_valid ? 2'b00 : (grant_write ? RGGEN_WRITE : RGGEN_READ);
    assign o_bus_address    = !bus_valid ? '0 : (grant_write ? aw_addr_q : ar_addr_q);
    assign o_bus_write_data = (bus_valid && grant_write) ? w_data_q : '0;
    assign o_bus_strobe     = (bus_valid && grant_write) ? w_strb_q : '0;

    rggen_axi4lite_response_fifo #(
        .WIDTH (B_W),
        .DEPTH (RESPONSE_DEPTH)
    ) u_b_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (write_done),
        .i_data  ({aw_id_q, i_bus_status}),
        .i_pop   (i_bready),
        .o_data  (b_head),
        .o_count (b_count),
        .o_full  (b_full_unused),
        .o_empty (b_empty)
    );

    rggen_axi4lite_response_fifo #(
        .WIDTH (R_W),
        .DEPTH (RESPONSE_DEPTH)
    ) u_r_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (read_done),
        .i_data  ({ar_id_q, i_bus_status, i_bus_read_data}),
        .i_pop   (i_rready),
        .o_data  (r_head),
        .o_count (r_count),
        .o_full  (r_full_unused),
        .o_empty (r_empty)
    );

    assign o_bvalid                  = !b_empty;
    assign {o_bid, o_bresp}          = b_head;
    assign o_rvalid                  = !r_empty;
    assign {o_rid, o_rresp, o_rdata} = r_head;

    // Protection bits carry no meaning for the register block.
    assign unused_inputs = ^{i_awprot, i_arprot, b_full_unused, r_full_unused};
endmodule

// File: tb/tb_rggen_axi4lite_pipelined_adapter.sv
// Directed and randomized bench: AXI master, register-bus slave and a
// transaction-level reference model (expected queues plus shadow memory).
module tb_rggen_axi4lite_pipelined_adapter;
    localparam logic [1:0] ACC_W = 2'b11;
    localparam logic [1:0] ACC_R = 2'b10;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_awvalid, o_awready, i_wvalid, o_wready, o_bvalid, i_bready;
    logic [3:0]  i_awid, o_bid, i_arid, o_rid;
    logic [7:0]  i_awaddr, i_araddr, o_bus_address;
    logic [2:0]  i_awprot, i_arprot;
    logic [31:0] i_wdata, o_rdata, o_bus_write_data, i_bus_read_data;
    logic [3:0]  i_wstrb, o_bus_strobe;
    logic [1:0]  o_bresp, o_rresp, o_bus_access, i_bus_status;
    logic        i_arvalid, o_arready, o_rvalid, i_rready;
    logic        o_bus_valid, i_bus_ready;

    rggen_axi4lite_pipelined_adapter #(
        .ID_WIDTH       (4),
        .ADDRESS_WIDTH  (8),
        .BUS_WIDTH      (32),
        .RESPONSE_DEPTH (2),
        .ARBITRATION    (2)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_awvalid        (i_awvalid),
        .o_awready        (o_awready),
        .i_awid           (i_awid),
        .i_awaddr         (i_awaddr),
        .i_awprot         (i_awprot),
        .i_wvalid         (i_wvalid),
        .o_wready         (o_wready),
        .i_wdata          (i_wdata),
        .i_wstrb          (i_wstrb),
        .o_bvalid         (o_bvalid),
        .i_bready         (i_bready),
        .o_bid            (o_bid),
        .o_bresp          (o_bresp),
        .i_arvalid        (i_arvalid),
        .o_arready        (o_arready),
        .i_arid           (i_arid),
        .i_araddr         (i_araddr),
        .i_arprot         (i_arprot),
        .o_rvalid         (o_rvalid),
        .i_rready         (i_rready),
        .o_rid            (o_rid),
        .o_rresp          (o_rresp),
        .o_rdata          (o_rdata),
        .o_bus_valid      (o_bus_valid),
        .o_bus_access     (o_bus_access),
        .o_bus_address    (o_bus_address),
        .o_bus_write_data (o_bus_write_data),
        .o_bus_strobe     (o_bus_strobe),
        .i_bus_ready      (i_bus_ready),
        .i_bus_status     (i_bus_status),
        .i_bus_read_data  (i_bus_read_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    int          n_assert = 0;
    int          n_fail = 0;
    rsp_t        exp_b[$];
    rsp_t        exp_r[$];
    logic [7:0]  exp_aw[$];
    logic [7:0]  exp_ar[$];
    logic [35:0] exp_w[$];
    bit          bus_log[$];
    logic [31:0] slave_mem[64];
    logic [31:0] shadow[64];
    int          rdy_mode = 0;
    logic [1:0]  cur_status = 2'b00;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit busy();
        return i_awvalid || i_wvalid || i_arvalid || exp_aw.size() > 0 || exp_w.size() > 0 ||
               exp_ar.size() > 0 || exp_b.size() > 0 || exp_r.size() > 0;
    endfunction

    // One clock: play the register slave, score every handshake, advance.
    task automatic tick();
        bit          hs_aw, hs_w, hs_ar, hs_b, hs_r, hs_bus;
        logic [7:0]  a;
        logic [35:0] w;
        rsp_t        r;
        case (rdy_mode)
            0:       i_bus_ready = 1'b1;
            1:       i_bus_ready = 1'b0;
            default: i_bus_ready = 1'($urandom_range(0, 1));
        endcase
        i_bus_status    = cur_status;
        i_bus_read_data = slave_mem[o_bus_address[7:2]];
        hs_aw  = i_awvalid && o_awready;
        hs_w   = i_wvalid && o_wready;
        hs_ar  = i_arvalid && o_arready;
        hs_b   = o_bvalid && i_bready;
        hs_r   = o_rvalid && i_rready;
        hs_bus = o_bus_valid && i_bus_ready;
        if (hs_bus) begin
            bus_log.push_back(o_bus_access == ACC_W);
            if (o_bus_access == ACC_W) begin
                chk("bus_wr_pending", (exp_aw.size() > 0) && (exp_w.size() > 0), 1);
                if (exp_aw.size() > 0 && exp_w.size() > 0) begin
                    a = exp_aw.pop_front();
                    w = exp_w.pop_front();
                    chk("bus_wr_addr", o_bus_address, a);
                    chk("bus_wr_data", o_bus_write_data, w[31:0]);
                    chk("bus_wr_strb", o_bus_strobe, w[35:32]);
                    for (int k = 0; k < 4; k++) begin
                        if (o_bus_strobe[k])
                            slave_mem[o_bus_address[7:2]][8*k +: 8] = o_bus_write_data[8*k +: 8];
                        if (w[32+k]) shadow[a[7:2]][8*k +: 8] = w[8*k +: 8];
                    end
                end
            end else begin
                chk("bus_access", o_bus_access, ACC_R);
                chk("bus_rd_pending", exp_ar.size() > 0, 1);
                if (exp_ar.size() > 0) begin
                    a = exp_ar.pop_front();
                    chk("bus_rd_addr", o_bus_address, a);
                    chk("bus_rd_strb", o_bus_strobe, 0);
                end
            end
        end
        if (hs_b) begin
            chk("b_pending", exp_b.size() > 0, 1);
            if (exp_b.size() > 0) begin
                r = exp_b.pop_front();
                chk("bid", o_bid, r.id);
                chk("bresp", o_bresp, r.resp);
            end
        end
        if (hs_r) begin
            chk("r_pending", exp_r.size() > 0, 1);
            if (exp_r.size() > 0) begin
                r = exp_r.pop_front();
                chk("rid", o_rid, r.id);
                chk("rresp", o_rresp, r.resp);
                chk("rdata", o_rdata, r.data);
            end
        end
        if (hs_aw) begin
            exp_aw.push_back(i_awaddr);
            exp_b.push_back('{id: i_awid, resp: cur_status, data: 32'h0});
        end
        if (hs_w) exp_w.push_back({i_wstrb, i_wdata});
        if (hs_ar) begin
            exp_ar.push_back(i_araddr);
            exp_r.push_back('{id: i_arid, resp: cur_status, data: shadow[i_araddr[7:2]]});
        end
        @(posedge i_clk);
        @(negedge i_clk);
        if (hs_aw) i_awvalid = 1'b0;
        if (hs_w)  i_wvalid  = 1'b0;
        if (hs_ar) i_arvalid = 1'b0;
    endtask

    task automatic issue_write(logic [7:0] a, logic [31:0] d, logic [3:0] s, logic [3:0] id);
        i_awvalid = 1'b1; i_awaddr = a; i_awid = id;
        i_wvalid  = 1'b1; i_wdata  = d; i_wstrb = s;
    endtask

    task automatic issue_read(logic [7:0] a, logic [3:0] id);
        i_arvalid = 1'b1; i_araddr = a; i_arid = id;
    endtask

    task automatic wait_accept(int max_cycles);
        int c = 0;
        while ((i_awvalid || i_wvalid || i_arvalid) && c < max_cycles) begin
            tick();
            c++;
        end
        chk("accept_timeout", i_awvalid || i_wvalid || i_arvalid, 0);
    endtask

    task automatic drain(int max_cycles);
        int c = 0;
        while (busy() && c < max_cycles) begin
            tick();
            c++;
        end
        chk("drain_timeout", busy(), 0);
    endtask

    task automatic rand_traffic(int nw, logic [7:0] wb, int nr, logic [7:0] rb, int max_cycles);
        int aw_left = nw;
        int w_left = nw;
        int ar_left = nr;
        int c = 0;
        while ((aw_left > 0 || w_left > 0 || ar_left > 0 || busy()) && c < max_cycles) begin
            if (!i_awvalid && aw_left > 0 && $urandom_range(0, 2) == 0) begin
                i_awvalid = 1'b1;
                i_awaddr  = wb + 8'(4 * $urandom_range(0, 15));
                i_awid    = 4'($urandom);
                aw_left--;
            end
            if (!i_wvalid && w_left > 0 && $urandom_range(0, 2) == 0) begin
                i_wvalid = 1'b1;
                i_wdata  = $urandom;
                i_wstrb  = 4'($urandom);
                w_left--;
            end
            if (!i_arvalid && ar_left > 0 && $urandom_range(0, 2) == 0) begin
                i_arvalid = 1'b1;
                i_araddr  = rb + 8'(4 * $urandom_range(0, 15));
                i_arid    = 4'($urandom);
                ar_left--;
            end
            i_bready = 1'($urandom_range(0, 3) != 0);
            i_rready = 1'($urandom_range(0, 3) != 0);
            tick();
            c++;
        end
        chk("rand_done", (aw_left + w_left + ar_left == 0) && !busy(), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_awvalid = 0; i_awid = 0; i_awaddr = 0; i_awprot = 3'b101;
        i_wvalid = 0; i_wdata = 0; i_wstrb = 0; i_bready = 0;
        i_arvalid = 0; i_arid = 0; i_araddr = 0; i_arprot = 3'b010; i_rready = 0;
        i_bus_ready = 0; i_bus_status = 0; i_bus_read_data = 0;
        for (int i = 0; i < 64; i++) begin
            slave_mem[i] = (32'h01010101 * i) ^ 32'hA5000000;
            shadow[i]    = slave_mem[i];
        end
        slave_mem[0] = 32'h11; shadow[0] = 32'h11;
        slave_mem[1] = 32'h22; shadow[1] = 32'h22;
        slave_mem[2] = 32'h33; shadow[2] = 32'h33;

        repeat (2) @(negedge i_clk);
        chk("rst_awready", o_awready, 1);
        chk("rst_wready", o_wready, 1);
        chk("rst_arready", o_arready, 1);
        chk("rst_bvalid", o_bvalid, 0);
        chk("rst_rvalid", o_rvalid, 0);
        chk("rst_bus_valid", o_bus_valid, 0);
        chk("rst_bus_access", o_bus_access, 0);
        chk("rst_rdata", o_rdata, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Write with AW three cycles ahead of W
        i_bready = 1; i_rready = 1;
        i_awvalid = 1; i_awaddr = 8'h10; i_awid = 4'h5;
        tick();
        chk("t1_awready_low", o_awready, 0);
        repeat (3) begin
            chk("t1_no_bus_before_w", o_bus_valid, 0);
            tick();
        end
        i_wvalid = 1; i_wdata = 32'hDEADBEEF; i_wstrb = 4'hF;
        chk("t1_no_bus_before_w", o_bus_valid, 0);
        tick();
        chk("t1_bus_valid", o_bus_valid, 1);
        chk("t1_bus_access", o_bus_access, ACC_W);
        chk("t1_bus_address", o_bus_address, 8'h10);
        chk("t1_bus_wdata", o_bus_write_data, 32'hDEADBEEF);
        chk("t1_bus_strobe", o_bus_strobe, 4'hF);
        chk("t1_bvalid_early", o_bvalid, 0);
        tick();
        chk("t1_bvalid", o_bvalid, 1);
        chk("t1_bresp", o_bresp, 0);
        chk("t1_bid", o_bid, 4'h5);
        tick();
        chk("t1_bvalid_popped", o_bvalid, 0);

        // Three reads with R queue blocked
        i_bready = 0; i_rready = 0;
        for (int k = 0; k < 3; k++) begin
            issue_read(8'(4 * k), 4'(k + 1));
            wait_accept(20);
        end
        repeat (3) begin
            chk("t2_third_stalled", o_bus_valid, 0);
            chk("t2_arready_low", o_arready, 0);
            chk("t2_rvalid", o_rvalid, 1);
            chk("t2_rdata_head", o_rdata, 32'h11);
            tick();
        end
        i_rready = 1;
        drain(40);

        // Error status and wide ID on a read
        cur_status = 2'b10;
        i_rready = 0;
        issue_read(8'h0C, 4'h9);
        wait_accept(20);
        for (int c = 0; c < 20 && !o_rvalid; c++) tick();
        chk("t5_rvalid", o_rvalid, 1);
        chk("t5_rid", o_rid, 4'h9);
        chk("t5_rresp", o_rresp, 2'b10);
        i_rready = 1;
        drain(20);
        cur_status = 2'b00;

        // Reset with two B responses queued and a locked read
        i_bready = 0;
        issue_write(8'h20, 32'h12345678, 4'hF, 4'h1);
        wait_accept(20);
        issue_write(8'h24, 32'h9ABCDEF0, 4'h3, 4'h2);
        wait_accept(20);
        for (int c = 0; c < 20 && exp_aw.size() > 0; c++) tick();
        chk("t6_writes_done", exp_aw.size(), 0);
        chk("t6_bvalid_before", o_bvalid, 1);
        rdy_mode = 1;
        issue_read(8'h28, 4'h3);
        wait_accept(20);
        tick();
        chk("t6_locked", o_bus_valid, 1);
        i_rst_n = 1'b0;
        i_awvalid = 0; i_wvalid = 0; i_arvalid = 0;
        #1;
        chk("t6_rst_bvalid", o_bvalid, 0);
        chk("t6_rst_bus_valid", o_bus_valid, 0);
        chk("t6_rst_awready", o_awready, 1);
        chk("t6_rst_arready", o_arready, 1);
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_b.delete(); exp_r.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        rdy_mode = 0;
        i_bready = 1; i_rready = 1;
        chk("t6_post_bvalid", o_bvalid, 0);
        chk("t6_post_bus_valid", o_bus_valid, 0);
        chk("t6_post_wready", o_wready, 1);
        chk("t6_post_arready", o_arready, 1);
        repeat (4) begin
            tick();
            chk("t6_no_stale_b", o_bvalid, 0);
            chk("t6_no_stale_bus", o_bus_valid, 0);
        end

        // Round-robin: conflict, lone write, conflict
        bus_log.delete();
        issue_write(8'h30, 32'hCAFE0001, 4'hF, 4'h1);
        issue_read(8'h34, 4'h2);
        drain(40);
        issue_write(8'h38, 32'hCAFE0002, 4'hF, 4'h3);
        drain(40);
        issue_write(8'h3C, 32'hCAFE0003, 4'hF, 4'h4);
        issue_read(8'h30, 4'h5);
        drain(40);
        chk("t3_grant_count", bus_log.size(), 5);
        for (int k = 0; k < 5 && k < bus_log.size(); k++)
            chk($sformatf("t3_grant%0d", k), bus_log[k], (k % 2 == 0));

        // Locked read is not pre-empted by a later write
        issue_read(8'h10, 4'h6);
        drain(20);
        bus_log.delete();
        rdy_mode = 1;
        issue_read(8'h14, 4'h7);
        wait_accept(20);
        chk("t4_read_valid", o_bus_valid, 1);
        chk("t4_read_addr", o_bus_address, 8'h14);
        issue_write(8'h88, 32'h0BADF00D, 4'hF, 4'h8);
        repeat (5) begin
            tick();
            chk("t4_hold_valid", o_bus_valid, 1);
            chk("t4_hold_access", o_bus_access, ACC_R);
            chk("t4_hold_addr", o_bus_address, 8'h14);
        end
        rdy_mode = 0;
        drain(40);
        chk("t4_grant_count", bus_log.size(), 2);
        if (bus_log.size() == 2) begin
            chk("t4_first_read", bus_log[0], 0);
            chk("t4_then_write", bus_log[1], 1);
        end

        // Randomized traffic against the shadow memory
        rdy_mode = 2;
        rand_traffic(12, 8'h40, 0, 8'h00, 2000);
        rand_traffic(12, 8'h80, 12, 8'h40, 3000);
        rand_traffic(0, 8'h00, 12, 8'h80, 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
